inst_trace_buffer: RTL and testbench

Captures the (pc, inst) pair produced by the single-cycle-visible dataflow wrapper each time the CPU enters its fetch state, and stamps each pair with a sequence number. Entries are buffered in an on-chip FIFO and drained through a valid/ready port. The block sits directly downstream of the CPU top-level wrapper and feeds the debug/UART trace path. Overflow is counted and never stalls the CPU.

---
 rtl/inst_trace_buffer_pkg.sv | 15 +
 rtl/inst_trace_buffer_if.sv | 27 ++
 rtl/inst_trace_buffer_fifo.sv | 51 +++++
 rtl/inst_trace_buffer.sv | 81 ++++++++
 tb/tb_inst_trace_buffer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_trace_buffer_pkg.sv
// Shared types and widths for the instruction trace buffer.
// One entry is {seq, pc, inst}, 80 bits.
package trace_pkg;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int SEQ_W  = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h00400000;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;
endpackage

// File: rtl/inst_trace_buffer_if.sv
// Valid/ready drain port of the trace buffer.
// The producer drives head data; the consumer drives ready.
interface inst_trace_buffer_if;
  import trace_pkg::*;

  logic              trace_valid;
  logic              trace_ready;
  logic [PC_W-1:0]   trace_pc;
  logic [INST_W-1:0] trace_inst;
  logic [SEQ_W-1:0]  trace_seq;

  modport master (
    output trace_valid,
    output trace_pc,
    output trace_inst,
    output trace_seq,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_pc,
    input  trace_inst,
    input  trace_seq,
    output trace_ready
  );
endinterface

// File: rtl/inst_trace_buffer_fifo.sv
// Generic synchronous show-ahead FIFO.
// Head reads as zero while empty; a push when full is dropped.
module trace_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count = wr_ptr_q - rd_ptr_q;
    // Full with a pop frees the head slot this edge.
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst)
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/inst_trace_buffer.sv
// Captures (pc, inst) on each fetch strobe, stamps a sequence
// number and buffers entries for a valid/ready consumer.
module inst_trace_buffer
  import trace_pkg::*;
#(
  parameter int              DEPTH    = 16,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter bit              DEDUP    = 1'b1,
  localparam int             CW       = $clog2(DEPTH) + 1
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                fetch_strobe,
  input  logic [PC_W-1:0]     pc_in,
  input  logic [INST_W-1:0]   inst_in,
  inst_trace_buffer_if.master trace,
  output logic [CW-1:0]       count,
  output logic                full,
  output logic [15:0]         overflow_cnt
);
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic [15:0]      ovf_q, ovf_d;
  logic             flush;
  logic             cap;
  logic             pop;
  logic             push_ok;
  logic             empty;
  entry_t           wr_entry;
  entry_t           head;

  always_comb begin
    flush    = reset || clear;
    cap      = fetch_strobe && enable &&
               !(DEDUP && (pc_in == last_pc_q));
    pop      = !empty && trace.trace_ready;
    push_ok  = cap && (!full || pop);
    wr_entry = '{seq: seq_q, pc: pc_in, inst: inst_in};
    seq_d     = cap ? seq_q + 1'b1 : seq_q;
    last_pc_d = cap ? pc_in : last_pc_q;
    ovf_d     = ovf_q;
    // Dropped captures still consume a seq, leaving a visible gap.
    if (cap && !push_ok && (ovf_q != 16'hFFFF))
      ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (flush) begin
      seq_q     <= '0;
      last_pc_q <= RESET_PC;
      ovf_q     <= '0;
    end else begin
      seq_q     <= seq_d;
      last_pc_q <= last_pc_d;
      ovf_q     <= ovf_d;
    end
  end

  trace_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (flush),
    .push  (push_ok),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign trace.trace_valid = !empty;
  assign trace.trace_pc    = head.pc;
  assign trace.trace_inst  = head.inst;
  assign trace.trace_seq   = head.seq;
  assign overflow_cnt      = ovf_q;
endmodule

// File: tb/tb_inst_trace_buffer.sv
// Directed bench for inst_trace_buffer, run with DEDUP on and off.
// Both instances share stimulus; each task checks its own scenario.
module tb_inst_trace_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic        fetch_strobe = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic        ready = 1'b0;

  logic [4:0]  count, count_nd;
  logic        full, full_nd;
  logic [15:0] ovf, ovf_nd;

  int total = 0;
  int bad = 0;

  inst_trace_buffer_if tif ();
  inst_trace_buffer_if tif_nd ();

  assign tif.trace_ready    = ready;
  assign tif_nd.trace_ready = ready;

  always #5 clk = ~clk;

  inst_trace_buffer #(.DEPTH(16), .DEDUP(1'b1)) u_dut (
    .clk_in       (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .fetch_strobe (fetch_strobe),
    .pc_in        (pc_in),
    .inst_in      (inst_in),
    .trace        (tif),
    .count        (count),
    .full         (full),
    .overflow_cnt (ovf)
  );

  inst_trace_buffer #(.DEPTH(16), .DEDUP(1'b0)) u_nd (
    .clk_in       (clk),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .fetch_strobe (fetch_strobe),
    .pc_in        (pc_in),
    .inst_in      (inst_in),
    .trace        (tif_nd),
    .count        (count_nd),
    .full         (full_nd),
    .overflow_cnt (ovf_nd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready = 1'b0;
    fetch_strobe = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] pc, input logic [31:0] inst);
    fetch_strobe = 1'b1;
    pc_in = pc;
    inst_in = inst;
    step();
    fetch_strobe = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tif.trace_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%0b want=0", tif.trace_valid);
    end
    total++;
    if (count !== 5'd0) begin
      bad++; $display("FAIL rst_count got=%0d want=0", count);
    end
    total++;
    if (full !== 1'b0 || ovf !== 16'd0) begin
      bad++; $display("FAIL rst_full_ovf got=%0b/%0d want=0/0", full, ovf);
    end
    total++;
    if ({tif.trace_seq, tif.trace_pc, tif.trace_inst} !== 80'd0) begin
      bad++; $display("FAIL rst_head got=%h/%h/%h want=0",
                      tif.trace_seq, tif.trace_pc, tif.trace_inst);
    end
  endtask

  task automatic test_basic();
    do_reset();
    fetch_strobe = 1'b1;
    pc_in = 32'h00400000;
    inst_in = 32'h3C010000;
    #1;
    total++;
    if (tif_nd.trace_valid !== 1'b0) begin
      bad++; $display("FAIL basic_no_bypass got=%0b want=0", tif_nd.trace_valid);
    end
    step();
    total++;
    if (tif_nd.trace_valid !== 1'b1) begin
      bad++; $display("FAIL basic_latency got=%0b want=1", tif_nd.trace_valid);
    end
    total++;
    if (tif.trace_valid !== 1'b0) begin
      bad++; $display("FAIL basic_dedup_resetpc got=%0b want=0", tif.trace_valid);
    end
    strobe(32'h00400004, 32'h34210001);
    total++;
    if (count_nd !== 5'd2 || tif_nd.trace_seq !== 16'd0) begin
      bad++; $display("FAIL basic_count_seq got=%0d/%0d want=2/0",
                      count_nd, tif_nd.trace_seq);
    end
    total++;
    if (tif_nd.trace_pc !== 32'h00400000 || tif_nd.trace_inst !== 32'h3C010000) begin
      bad++; $display("FAIL basic_head got=%h/%h want=00400000/3c010000",
                      tif_nd.trace_pc, tif_nd.trace_inst);
    end
    total++;
    if (count !== 5'd1 || tif.trace_pc !== 32'h00400004 || tif.trace_seq !== 16'd0) begin
      bad++; $display("FAIL basic_dedup_head got=%0d/%h/%0d want=1/00400004/0",
                      count, tif.trace_pc, tif.trace_seq);
    end
    enable = 1'b0;
    strobe(32'h00000500, 32'h1);
    enable = 1'b1;
    total++;
    if (count_nd !== 5'd2) begin
      bad++; $display("FAIL basic_enable_off got=%0d want=2", count_nd);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    total++;
    if (tif_nd.trace_seq !== 16'd1 || tif_nd.trace_pc !== 32'h00400004) begin
      bad++; $display("FAIL basic_pop got=%0d/%h want=1/00400004",
                      tif_nd.trace_seq, tif_nd.trace_pc);
    end
    total++;
    if (tif.trace_valid !== 1'b0 || tif.trace_seq !== 16'd0) begin
      bad++; $display("FAIL basic_empty_head got=%0b/%0d want=0/0",
                      tif.trace_valid, tif.trace_seq);
    end
  endtask

  task automatic test_dedup();
    do_reset();
    strobe(32'h00400008, 32'hA);
    strobe(32'h00400008, 32'hB);
    strobe(32'h0040000C, 32'hC);
    total++;
    if (count !== 5'd2 || ovf !== 16'd0) begin
      bad++; $display("FAIL dedup_count got=%0d/%0d want=2/0", count, ovf);
    end
    total++;
    if (count_nd !== 5'd3 || ovf_nd !== 16'd0) begin
      bad++; $display("FAIL nodedup_count got=%0d/%0d want=3/0", count_nd, ovf_nd);
    end
    total++;
    if (tif.trace_seq !== 16'd0 || tif.trace_pc !== 32'h00400008) begin
      bad++; $display("FAIL dedup_head0 got=%0d/%h want=0/00400008",
                      tif.trace_seq, tif.trace_pc);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    total++;
    if (tif.trace_seq !== 16'd1 || tif.trace_pc !== 32'h0040000C) begin
      bad++; $display("FAIL dedup_head1 got=%0d/%h want=1/0040000c",
                      tif.trace_seq, tif.trace_pc);
    end
    total++;
    if (tif_nd.trace_seq !== 16'd1 || tif_nd.trace_pc !== 32'h00400008) begin
      bad++; $display("FAIL nodedup_head1 got=%0d/%h want=1/00400008",
                      tif_nd.trace_seq, tif_nd.trace_pc);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++)
      strobe(32'h1000 + 32'(i * 4), 32'(i));
    total++;
    if (full !== 1'b1 || count !== 5'd16 || ovf !== 16'd4) begin
      bad++; $display("FAIL ovf_state got=%0b/%0d/%0d want=1/16/4", full, count, ovf);
    end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (tif.trace_valid !== 1'b1 || tif.trace_seq !== 16'(i)) begin
        bad++; $display("FAIL ovf_drain got=%0b/%0d want=1/%0d",
                        tif.trace_valid, tif.trace_seq, i);
      end
      step();
    end
    ready = 1'b0;
    total++;
    if (tif.trace_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL ovf_drained got=%0b/%0d want=0/0", tif.trace_valid, count);
    end
    strobe(32'h2000, 32'h55);
    total++;
    if (tif.trace_seq !== 16'd20 || count !== 5'd1) begin
      bad++; $display("FAIL ovf_gap got=%0d/%0d want=20/1", tif.trace_seq, count);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 16; i++)
      strobe(32'h4000 + 32'(i * 4), 32'(i));
    total++;
    if (full !== 1'b1 || full_nd !== 1'b1) begin
      bad++; $display("FAIL fp_full got=%0b/%0b want=1/1", full, full_nd);
    end
    ready = 1'b1;
    strobe(32'h5000, 32'hDEAD);
    ready = 1'b0;
    total++;
    if (count !== 5'd16 || full !== 1'b1 || ovf !== 16'd0) begin
      bad++; $display("FAIL fp_state got=%0d/%0b/%0d want=16/1/0", count, full, ovf);
    end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (tif.trace_seq !== 16'(i + 1)) begin
        bad++; $display("FAIL fp_drain got=%0d want=%0d", tif.trace_seq, i + 1);
      end
      if (i == 15) begin
        total++;
        if (tif.trace_pc !== 32'h5000 || tif.trace_inst !== 32'hDEAD) begin
          bad++; $display("FAIL fp_tail got=%h/%h want=00005000/0000dead",
                          tif.trace_pc, tif.trace_inst);
        end
      end
      step();
    end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      strobe(32'h6000 + 32'(i * 4), 32'(i));
      total++;
      if (count > 5'd1) begin
        bad++; $display("FAIL b2b_count got=%0d want<=1", count);
      end
      total++;
      if (tif.trace_valid !== 1'b1 || tif.trace_seq !== 16'(i)) begin
        bad++; $display("FAIL b2b_seq got=%0b/%0d want=1/%0d",
                        tif.trace_valid, tif.trace_seq, i);
      end
    end
    step();
    ready = 1'b0;
    total++;
    if (count !== 5'd0) begin
      bad++; $display("FAIL b2b_final got=%0d want=0", count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 19; i++)
      strobe(32'h7000 + 32'(i * 4), 32'(i));
    ready = 1'b1;
    repeat (11) step();
    ready = 1'b0;
    total++;
    if (count !== 5'd5 || ovf !== 16'd3) begin
      bad++; $display("FAIL clr_pre got=%0d/%0d want=5/3", count, ovf);
    end
    clear = 1'b1;
    fetch_strobe = 1'b1;
    pc_in = 32'h8000;
    step();
    clear = 1'b0;
    fetch_strobe = 1'b0;
    total++;
    if (count !== 5'd0 || tif.trace_valid !== 1'b0 || ovf !== 16'd0 || full !== 1'b0) begin
      bad++; $display("FAIL clr_state got=%0d/%0b/%0d/%0b want=0/0/0/0",
                      count, tif.trace_valid, ovf, full);
    end
    strobe(32'h8004, 32'h77);
    total++;
    if (tif.trace_seq !== 16'd0 || count !== 5'd1 || tif.trace_pc !== 32'h8004) begin
      bad++; $display("FAIL clr_seq got=%0d/%0d/%h want=0/1/00008004",
                      tif.trace_seq, count, tif.trace_pc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dedup();
    test_overflow();
    test_full_pop();
    test_back_to_back();
    test_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
